// File: rtl/stage2_unpooling_pkg.sv
// stage2_unpooling_pkg
//   Shared constants and types for the stage-2 unpooling block.
//   - ST2_POOL_IBW / ST2_UNPOOL_IBW : pixel width of the stage-2 pool path
//   - ST2_UNPOOL_X / ST2_UNPOOL_Y   : default output frame size
//   - unpool_state_e                : row-parity state (even rows load, odd rows replay)
//   - lb_addr_w()                   : address width of the half-width line buffer
package stage2_unpooling_pkg;

    localparam int ST2_POOL_IBW   = 19;
    localparam int ST2_UNPOOL_IBW = ST2_POOL_IBW;
    localparam int ST2_UNPOOL_X   = 24;
    localparam int ST2_UNPOOL_Y   = 24;

    typedef enum logic {
        S_EVEN = 1'b0,
        S_ODD  = 1'b1
    } unpool_state_e;

    // One line-buffer entry per input column (OUT_X/2), at least one address bit.
    function automatic int lb_addr_w(input int out_x);
        return (out_x / 2 > 1) ? $clog2(out_x / 2) : 1;
    endfunction

endpackage

// File: rtl/stage2_unpooling_line_buffer.sv
// stage2_unpooling_line_buffer
//   Unpool line buffer: holds one row of pooled pixels so the odd output row
//   can replay the even row without re-reading the input stream.
//   Ports:
//     clk      : clock
//     i_we     : write enable (one write per accepted input pixel)
//     i_waddr  : write address (input column)
//     i_wdata  : pixel to store
//     i_raddr  : read address (input column)
//     o_rdata  : combinational read data
//   Storage is not reset; every entry is written on the even row before the
//   odd row reads it.
module stage2_unpooling_line_buffer #(
    parameter int IBW   = 19,
    parameter int DEPTH = 12,
    parameter int AW    = 4
) (
    input  logic           clk,
    input  logic           i_we,
    input  logic [AW-1:0]  i_waddr,
    input  logic [IBW-1:0] i_wdata,
    input  logic [AW-1:0]  i_raddr,
    output logic [IBW-1:0] o_rdata
);

    logic [IBW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stage2_unpooling.sv
// stage2_unpooling
//   2x upsampling stage (inverse of the stage-2 2x2 max pool). Consumes a
//   raster of OUT_X/2 x OUT_Y/2 pooled pixels and produces an OUT_X x OUT_Y
//   raster. Default: nearest-neighbour replication into each 2x2 block.
//   Build option UNPOOL_ZERO_FILL_EN: zero-insertion unpooling; only the
//   top-left pixel of each block carries data, no line buffer is built.
//   Ports:
//     clk, reset          : clock, synchronous active-high reset
//     i_in_valid/i_in_fmap: input pixel stream
//     o_in_ready          : input accepted this cycle (combinational)
//     o_ot_valid/o_ot_fmap: output pixel stream (registered)
//     o_ot_last           : marks the final pixel of the output frame
//     i_ot_ready          : downstream accepts the output this cycle
//
//   state  | meaning
//   S_EVEN | output rows 0,2,..: phase 0 loads a new input, phase 1 repeats it
//   S_ODD  | output rows 1,3,..: replay the stored row, no input accepted
module stage2_unpooling
    import stage2_unpooling_pkg::*;
#(
    parameter int IBW   = ST2_UNPOOL_IBW,
    parameter int OUT_X = ST2_UNPOOL_X,
    parameter int OUT_Y = ST2_UNPOOL_Y
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_in_valid,
    input  logic [IBW-1:0] i_in_fmap,
    output logic           o_in_ready,
    output logic           o_ot_valid,
    output logic [IBW-1:0] o_ot_fmap,
    output logic           o_ot_last,
    input  logic           i_ot_ready
);

    localparam int CW = (OUT_X > 1) ? $clog2(OUT_X) : 1;
    localparam int RW = (OUT_Y > 1) ? $clog2(OUT_Y) : 1;

    unpool_state_e  r_state;
    logic           r_phase;
    logic [CW-1:0]  r_out_col;
    logic [RW-1:0]  r_out_row;
    logic           r_ot_valid;
    logic [IBW-1:0] r_ot_fmap;
    logic           r_ot_last;

    logic           w_slot_free;
    logic           w_in_ready;
    logic           w_in_xfer;
    logic           w_col_end;
    logic           w_row_end;
    logic [IBW-1:0] w_even_rep;
    logic [IBW-1:0] w_odd_data;

    assign w_slot_free = !r_ot_valid || i_ot_ready;
    assign w_in_ready  = (r_state == S_EVEN) && !r_phase && w_slot_free;
    assign w_in_xfer   = i_in_valid && w_in_ready;
    assign w_col_end   = (r_out_col == CW'(OUT_X - 1));
    assign w_row_end   = (r_out_row == RW'(OUT_Y - 1));

`ifdef UNPOOL_ZERO_FILL_EN
    assign w_even_rep = '0;
    assign w_odd_data = '0;
`else
    localparam int LB_AW = lb_addr_w(OUT_X);

    logic [LB_AW-1:0] w_lb_addr;

    // Each input column covers two output columns.
    assign w_lb_addr  = LB_AW'(r_out_col >> 1);
    assign w_even_rep = r_ot_fmap;

    stage2_unpooling_line_buffer #(
        .IBW   (IBW),
        .DEPTH (OUT_X / 2),
        .AW    (LB_AW)
    ) u_line_buffer (
        .clk     (clk),
        .i_we    (w_in_xfer),
        .i_waddr (w_lb_addr),
        .i_wdata (i_in_fmap),
        .i_raddr (w_lb_addr),
        .o_rdata (w_odd_data)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_EVEN;
            r_phase    <= 1'b0;
            r_out_col  <= '0;
            r_out_row  <= '0;
            r_ot_valid <= 1'b0;
            r_ot_fmap  <= '0;
            r_ot_last  <= 1'b0;
        end else begin
            case (r_state)
                S_EVEN: begin
                    if (!r_phase) begin
                        if (w_in_xfer) begin
                            r_ot_fmap  <= i_in_fmap;
                            r_ot_valid <= 1'b1;
                            r_ot_last  <= 1'b0;
                            r_phase    <= 1'b1;
                            r_out_col  <= r_out_col + CW'(1);
                        end else if (w_slot_free) begin
                            r_ot_valid <= 1'b0;
                            r_ot_last  <= 1'b0;
                        end
                    end else if (w_slot_free) begin
                        r_ot_fmap  <= w_even_rep;
                        r_ot_valid <= 1'b1;
                        r_ot_last  <= 1'b0;
                        r_phase    <= 1'b0;
                        if (w_col_end) begin
                            r_out_col <= '0;
                            r_out_row <= r_out_row + RW'(1);
                            r_state   <= S_ODD;
                        end else begin
                            r_out_col <= r_out_col + CW'(1);
                        end
                    end
                end
                S_ODD: begin
                    if (w_slot_free) begin
                        r_ot_fmap  <= w_odd_data;
                        r_ot_valid <= 1'b1;
                        if (w_col_end) begin
                            r_out_col <= '0;
                            r_state   <= S_EVEN;
                            if (w_row_end) begin
                                r_ot_last <= 1'b1;
                                r_out_row <= '0;
                            end else begin
                                r_ot_last <= 1'b0;
                                r_out_row <= r_out_row + RW'(1);
                            end
                        end else begin
                            r_ot_last <= 1'b0;
                            r_out_col <= r_out_col + CW'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign o_in_ready = w_in_ready;
    assign o_ot_valid = r_ot_valid;
    assign o_ot_fmap  = r_ot_fmap;
    assign o_ot_last  = r_ot_last;

endmodule

// File: tb/tb_stage2_unpooling.sv
// tb_stage2_unpooling
//   Drives a 4x4 instance and a default 24x24 instance of stage2_unpooling
//   through a shared stream driver; expected output is derived from the
//   block-replication rule (or zero insertion under UNPOOL_ZERO_FILL_EN).
module tb_stage2_unpooling;
    import stage2_unpooling_pkg::*;

    localparam int W = ST2_UNPOOL_IBW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         sel;            // 0: 4x4 instance, 1: 24x24 instance
    logic         drv_in_valid;
    logic [W-1:0] drv_in_fmap;
    logic         drv_ot_ready;

    logic         s_in_valid, s_in_ready, s_ot_valid, s_ot_last, s_ot_ready;
    logic [W-1:0] s_ot_fmap;
    logic         b_in_valid, b_in_ready, b_ot_valid, b_ot_last, b_ot_ready;
    logic [W-1:0] b_ot_fmap;

    logic         m_in_ready, m_ot_valid, m_ot_last;
    logic [W-1:0] m_ot_fmap;

    assign s_in_valid = !sel && drv_in_valid;
    assign b_in_valid = sel && drv_in_valid;
    assign s_ot_ready = sel ? 1'b1 : drv_ot_ready;
    assign b_ot_ready = sel ? drv_ot_ready : 1'b1;
    assign m_in_ready = sel ? b_in_ready : s_in_ready;
    assign m_ot_valid = sel ? b_ot_valid : s_ot_valid;
    assign m_ot_fmap  = sel ? b_ot_fmap : s_ot_fmap;
    assign m_ot_last  = sel ? b_ot_last : s_ot_last;

    stage2_unpooling #(.IBW(W), .OUT_X(4), .OUT_Y(4)) dut_small (
        .clk        (clk),
        .reset      (reset),
        .i_in_valid (s_in_valid),
        .i_in_fmap  (drv_in_fmap),
        .o_in_ready (s_in_ready),
        .o_ot_valid (s_ot_valid),
        .o_ot_fmap  (s_ot_fmap),
        .o_ot_last  (s_ot_last),
        .i_ot_ready (s_ot_ready)
    );

    stage2_unpooling dut_big (
        .clk        (clk),
        .reset      (reset),
        .i_in_valid (b_in_valid),
        .i_in_fmap  (drv_in_fmap),
        .o_in_ready (b_in_ready),
        .o_ot_valid (b_ot_valid),
        .o_ot_fmap  (b_ot_fmap),
        .o_ot_last  (b_ot_last),
        .i_ot_ready (b_ot_ready)
    );

    int errors = 0;
    int checks = 0;

    int           in_q[$];
    logic [W-1:0] exp_f[$];
    logic         exp_l[$];
    logic [W-1:0] got_f[$];
    logic         got_l[$];
    int           stall_bad;
    int           rdy_bad;
    int           bubbles;

    // Reference: output (r,c) of a frame is input (r/2, c/2); with zero fill
    // only the top-left of each 2x2 block carries the input value.
    function automatic void build_expected(input int nx, input int ny, input int nframes);
        int v;
        exp_f.delete();
        exp_l.delete();
        for (int f = 0; f < nframes; f++) begin
            for (int r = 0; r < ny; r++) begin
                for (int c = 0; c < nx; c++) begin
                    v = in_q[f * (nx / 2) * (ny / 2) + (r / 2) * (nx / 2) + c / 2];
`ifdef UNPOOL_ZERO_FILL_EN
                    if ((r % 2) != 0 || (c % 2) != 0) v = 0;
`endif
                    exp_f.push_back(W'(v));
                    exp_l.push_back((r == ny - 1) && (c == nx - 1));
                end
            end
        end
    endfunction

    // Stream driver: inputs change and outputs are sampled 1 time unit after the
    // falling edge; transfers are recorded for the coming rising edge.
    // ready_mode 0: always ready, 1: pattern 1,0,0,1 repeating, 2: random (~75%).
    task automatic run_stream(input int nx, input int ny, input int nframes,
                              input int ready_mode, input int gap_after, input int gap_len,
                              input int stop_after, output int timed_out);
        int           nout;
        int           idx;
        int           cyc;
        int           gap_cnt;
        int           pos;
        bit           gap_in;
        bit           stalled;
        logic [W-1:0] hold_f;
        logic         hold_l;
        nout = nx * ny * nframes;
        idx = 0; cyc = 0; gap_cnt = 0; stalled = 1'b0;
        hold_f = '0; hold_l = 1'b0;
        timed_out = 0;
        got_f.delete(); got_l.delete();
        stall_bad = 0; rdy_bad = 0; bubbles = 0;
        while (got_f.size() < nout) begin
            if (cyc > 20 * nout + 100) begin
                timed_out = 1;
                break;
            end
            @(negedge clk);
            case (ready_mode)
                0:       drv_ot_ready = 1'b1;
                1:       drv_ot_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: drv_ot_ready = ($urandom_range(0, 3) != 0);
            endcase
            gap_in = (gap_after >= 0) && (idx == gap_after) && (gap_cnt < gap_len);
            if (gap_in) gap_cnt++;
            drv_in_valid = (idx < in_q.size()) && !gap_in;
            drv_in_fmap  = (idx < in_q.size()) ? W'(in_q[idx]) : '0;
            #1;
            if (gap_in && !m_ot_valid) bubbles++;
            if (stalled) begin
                if (!(m_ot_valid === 1'b1 && m_ot_fmap === hold_f && m_ot_last === hold_l))
                    stall_bad++;
            end
            stalled = m_ot_valid && !drv_ot_ready;
            hold_f  = m_ot_fmap;
            hold_l  = m_ot_last;
            if (stalled && m_in_ready) rdy_bad++;
            if (m_ot_valid && drv_ot_ready) begin
                got_f.push_back(m_ot_fmap);
                got_l.push_back(m_ot_last);
            end
            if (drv_in_valid && m_in_ready) begin
                // The accepted pixel becomes output number got_f.size(); it must
                // be the top-left of a 2x2 block.
                pos = got_f.size() % (nx * ny);
                if (((pos / nx) % 2) != 0 || ((pos % nx) % 2) != 0) rdy_bad++;
                idx++;
                if (idx == stop_after) return;
            end
            cyc++;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        drv_in_valid = 1'b0;
        drv_ot_ready = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        sel = 1'b0;
        apply_reset();
        checks++; if (s_ot_valid !== 1'b0) begin errors++; $display("FAIL reset_s_valid: got %b expected 0", s_ot_valid); end
        checks++; if (s_ot_fmap !== '0) begin errors++; $display("FAIL reset_s_fmap: got %0h expected 0", s_ot_fmap); end
        checks++; if (s_ot_last !== 1'b0) begin errors++; $display("FAIL reset_s_last: got %b expected 0", s_ot_last); end
        checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL reset_s_in_ready: got %b expected 1", s_in_ready); end
        checks++; if (b_ot_valid !== 1'b0 || b_ot_fmap !== '0 || b_ot_last !== 1'b0) begin
            errors++; $display("FAIL reset_b_outputs: got v=%b f=%0h l=%b expected all 0", b_ot_valid, b_ot_fmap, b_ot_last);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic_frame();
        int to;
        sel = 1'b0;
        in_q = '{1, 2, 3, 4};
        build_expected(4, 4, 1);
        run_stream(4, 4, 1, 0, -1, 0, -1, to);
        checks++; if (to != 0 || got_f.size() != 16) begin errors++; $display("FAIL basic_count: got %0d outputs expected 16 (timeout=%0d)", got_f.size(), to); end
        for (int i = 0; i < got_f.size(); i++) begin
            checks++; if (got_f[i] !== exp_f[i]) begin errors++; $display("FAIL basic_fmap[%0d]: got %0h expected %0h", i, got_f[i], exp_f[i]); end
            checks++; if (got_l[i] !== exp_l[i]) begin errors++; $display("FAIL basic_last[%0d]: got %b expected %b", i, got_l[i], exp_l[i]); end
        end
        checks++; if (rdy_bad != 0) begin errors++; $display("FAIL basic_in_ready: got %0d bad accepts expected 0", rdy_bad); end
    endtask

    task automatic test_backpressure();
        int to;
        sel = 1'b0;
        in_q = '{1, 2, 3, 4};
        build_expected(4, 4, 1);
        run_stream(4, 4, 1, 1, -1, 0, -1, to);
        checks++; if (to != 0 || got_f.size() != 16) begin errors++; $display("FAIL bp_count: got %0d outputs expected 16 (timeout=%0d)", got_f.size(), to); end
        for (int i = 0; i < got_f.size(); i++) begin
            checks++; if (got_f[i] !== exp_f[i] || got_l[i] !== exp_l[i]) begin
                errors++; $display("FAIL bp_pixel[%0d]: got %0h/%b expected %0h/%b", i, got_f[i], got_l[i], exp_f[i], exp_l[i]);
            end
        end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable stalls expected 0", stall_bad); end
        checks++; if (rdy_bad != 0) begin errors++; $display("FAIL bp_in_ready: got %0d bad accepts expected 0", rdy_bad); end
    endtask

    task automatic test_input_gap();
        int to;
        sel = 1'b0;
        in_q = '{5, 6, 7, 8};
        build_expected(4, 4, 1);
        run_stream(4, 4, 1, 0, 1, 5, -1, to);
        checks++; if (to != 0 || got_f.size() != 16) begin errors++; $display("FAIL gap_count: got %0d outputs expected 16 (timeout=%0d)", got_f.size(), to); end
        for (int i = 0; i < got_f.size(); i++) begin
            checks++; if (got_f[i] !== exp_f[i] || got_l[i] !== exp_l[i]) begin
                errors++; $display("FAIL gap_pixel[%0d]: got %0h/%b expected %0h/%b", i, got_f[i], got_l[i], exp_f[i], exp_l[i]);
            end
        end
        // Pixel 5 fills the first two gap cycles (load then repeat); the other three are bubbles.
        checks++; if (bubbles != 3) begin errors++; $display("FAIL gap_bubbles: got %0d expected 3", bubbles); end
    endtask

    task automatic test_reset_midframe();
        int to;
        sel = 1'b0;
        in_q = '{1, 2, 3, 4};
        run_stream(4, 4, 1, 0, -1, 0, 3, to);
        apply_reset();
        checks++; if (s_ot_valid !== 1'b0 || s_ot_fmap !== '0 || s_ot_last !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs: got v=%b f=%0h l=%b expected all 0", s_ot_valid, s_ot_fmap, s_ot_last);
        end
        reset = 1'b0;
        in_q = '{9, 8, 7, 6};
        build_expected(4, 4, 1);
        run_stream(4, 4, 1, 0, -1, 0, -1, to);
        checks++; if (to != 0 || got_f.size() != 16) begin errors++; $display("FAIL midreset_count: got %0d outputs expected 16 (timeout=%0d)", got_f.size(), to); end
        for (int i = 0; i < got_f.size(); i++) begin
            checks++; if (got_f[i] !== exp_f[i] || got_l[i] !== exp_l[i]) begin
                errors++; $display("FAIL midreset_pixel[%0d]: got %0h/%b expected %0h/%b", i, got_f[i], got_l[i], exp_f[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_random_small();
        int to;
        sel = 1'b0;
        in_q.delete();
        for (int i = 0; i < 12; i++) in_q.push_back(int'($urandom_range(0, (1 << W) - 1)));
        build_expected(4, 4, 3);
        run_stream(4, 4, 3, 2, -1, 0, -1, to);
        checks++; if (to != 0 || got_f.size() != 48) begin errors++; $display("FAIL rnd4_count: got %0d outputs expected 48 (timeout=%0d)", got_f.size(), to); end
        for (int i = 0; i < got_f.size(); i++) begin
            checks++; if (got_f[i] !== exp_f[i] || got_l[i] !== exp_l[i]) begin
                errors++; $display("FAIL rnd4_pixel[%0d]: got %0h/%b expected %0h/%b", i, got_f[i], got_l[i], exp_f[i], exp_l[i]);
            end
        end
        checks++; if (stall_bad != 0 || rdy_bad != 0) begin errors++; $display("FAIL rnd4_handshake: got stall=%0d ready=%0d expected 0/0", stall_bad, rdy_bad); end
    endtask

    task automatic test_back_to_back();
        int to;
        int nlast;
        sel = 1'b1;
        in_q.delete();
        for (int i = 0; i < 2 * 144; i++) in_q.push_back(int'($urandom_range(0, (1 << W) - 1)));
        build_expected(24, 24, 2);
        run_stream(24, 24, 2, 2, -1, 0, -1, to);
        checks++; if (to != 0 || got_f.size() != 1152) begin errors++; $display("FAIL b2b_count: got %0d outputs expected 1152 (timeout=%0d)", got_f.size(), to); end
        nlast = 0;
        for (int i = 0; i < got_f.size(); i++) begin
            if (got_l[i] === 1'b1) nlast++;
            checks++; if (got_f[i] !== exp_f[i] || got_l[i] !== exp_l[i]) begin
                errors++; $display("FAIL b2b_pixel[%0d]: got %0h/%b expected %0h/%b", i, got_f[i], got_l[i], exp_f[i], exp_l[i]);
            end
        end
        checks++; if (nlast != 2) begin errors++; $display("FAIL b2b_last_count: got %0d expected 2", nlast); end
        checks++; if (stall_bad != 0 || rdy_bad != 0) begin errors++; $display("FAIL b2b_handshake: got stall=%0d ready=%0d expected 0/0", stall_bad, rdy_bad); end
        sel = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        sel = 1'b0;
        drv_in_valid = 1'b0;
        drv_in_fmap = '0;
        drv_ot_ready = 1'b1;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_input_gap();
        test_reset_midframe();
        test_random_small();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
